// File: rtl/mips_pkg.sv
// Shared constants and helpers for the pipelined MIPS register-file slice.
package mips_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned DEPTH_DEF = 32;
    localparam int unsigned REG_ZERO  = 0;

    // log2 of a power-of-two register count
    function automatic int unsigned addr_width(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) <= depth) w = i;
        end
        return w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: writes clear, issue sets; issue wins over a same-cycle write.
module rf_scoreboard
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned ADDR_W   = addr_width(DEPTH),
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              write0_en_i,
    input  logic [ADDR_W-1:0] write0_addr_i,
    input  logic              write1_en_i,
    input  logic [ADDR_W-1:0] write1_addr_i,
    input  logic              issue_en_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    output logic [DEPTH-1:0]  busy_o,
    output logic              busy_any_o
);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic             issue_ok;

    assign issue_ok = issue_en_i && !(ZERO_REG && issue_addr_i == ADDR_W'(REG_ZERO));

    always_comb begin
        busy_d = busy_q;
        if (write0_en_i) busy_d[write0_addr_i] = 1'b0;
        if (write1_en_i) busy_d[write1_addr_i] = 1'b0;
        if (issue_ok)    busy_d[issue_addr_i]  = 1'b1;
        if (ZERO_REG)    busy_d[REG_ZERO]      = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) busy_q <= '0;
        else         busy_q <= busy_d;
    end

    assign busy_o     = busy_q;
    assign busy_any_o = |busy_q;

endmodule

// File: rtl/register_file_pipe.sv
// Multi-read, dual-write register file with optional write bypass and RAW scoreboard.
module register_file_pipe
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned ADDR_W   = addr_width(DEPTH),
    parameter int unsigned NUM_READ = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_READ*ADDR_W-1:0] read_addr,
    output logic [NUM_READ*WIDTH-1:0]  read_data,
    output logic [NUM_READ-1:0]        read_busy,
    input  logic                       write0_en,
    input  logic [ADDR_W-1:0]          write0_addr,
    input  logic [WIDTH-1:0]           write0_data,
    input  logic                       write1_en,
    input  logic [ADDR_W-1:0]          write1_addr,
    input  logic [WIDTH-1:0]           write1_data,
    input  logic                       issue_en,
    input  logic [ADDR_W-1:0]          issue_addr,
    output logic                       busy_any
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             w0_ok, w1_ok;

    assign w0_ok = write0_en && !(ZERO_REG && write0_addr == ADDR_W'(REG_ZERO));
    assign w1_ok = write1_en && !(ZERO_REG && write1_addr == ADDR_W'(REG_ZERO));

    // Port 1 is applied last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else begin
            if (w0_ok) mem_q[write0_addr] <= write0_data;
            if (w1_ok) mem_q[write1_addr] <= write1_data;
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i         (clk),
        .reset_i       (reset),
        .write0_en_i   (write0_en),
        .write0_addr_i (write0_addr),
        .write1_en_i   (write1_en),
        .write1_addr_i (write1_addr),
        .issue_en_i    (issue_en),
        .issue_addr_i  (issue_addr),
        .busy_o        (busy),
        .busy_any_o    (busy_any)
    );

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [ADDR_W-1:0] ra;
        logic              is_zero, hit0, hit1;
        logic [WIDTH-1:0]  rd;
        logic              rb;

        assign ra      = read_addr[i*ADDR_W +: ADDR_W];
        assign is_zero = ZERO_REG && ra == ADDR_W'(REG_ZERO);
        assign hit0    = BYPASS && write0_en && write0_addr == ra;
        assign hit1    = BYPASS && write1_en && write1_addr == ra;

        always_comb begin
            rd = mem_q[ra];
            rb = busy[ra];
            if (hit1)      rd = write1_data;
            else if (hit0) rd = write0_data;
            if (hit0 || hit1) rb = 1'b0;
            if (is_zero) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign read_data[i*WIDTH +: WIDTH] = rd;
        assign read_busy[i]                = rb;
    end

endmodule

// File: tb/tb_register_file_pipe.sv
// Directed bench: default config, a BYPASS=0 twin and a 3-read-port twin share write/issue stimulus.
module tb_register_file_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        w0_en, w1_en, iss_en;
    logic [4:0]  w0_addr, w1_addr, iss_addr;
    logic [31:0] w0_data, w1_data;

    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rb;
    logic        bany;

    logic [9:0]  nb_ra;
    logic [63:0] nb_rd;
    logic [1:0]  nb_rb;
    logic        nb_bany;

    logic [14:0] t3_ra;
    logic [95:0] t3_rd;
    logic [2:0]  t3_rb;
    logic        t3_bany;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    register_file_pipe u_dut (
        .clk(clk), .reset(reset), .read_addr(ra), .read_data(rd), .read_busy(rb),
        .write0_en(w0_en), .write0_addr(w0_addr), .write0_data(w0_data),
        .write1_en(w1_en), .write1_addr(w1_addr), .write1_data(w1_data),
        .issue_en(iss_en), .issue_addr(iss_addr), .busy_any(bany)
    );

    register_file_pipe #(.BYPASS(1'b0)) u_nobyp (
        .clk(clk), .reset(reset), .read_addr(nb_ra), .read_data(nb_rd), .read_busy(nb_rb),
        .write0_en(w0_en), .write0_addr(w0_addr), .write0_data(w0_data),
        .write1_en(w1_en), .write1_addr(w1_addr), .write1_data(w1_data),
        .issue_en(iss_en), .issue_addr(iss_addr), .busy_any(nb_bany)
    );

    register_file_pipe #(.NUM_READ(3)) u_three (
        .clk(clk), .reset(reset), .read_addr(t3_ra), .read_data(t3_rd), .read_busy(t3_rb),
        .write0_en(w0_en), .write0_addr(w0_addr), .write0_data(w0_data),
        .write1_en(w1_en), .write1_addr(w1_addr), .write1_data(w1_data),
        .issue_en(iss_en), .issue_addr(iss_addr), .busy_any(t3_bany)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w0_en = 1'b0; w1_en = 1'b0; iss_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        w0_en = 1'b1; w0_addr = 5'd4; w0_data = 32'hDEAD;
        w1_en = 1'b0; w1_addr = 5'd0; w1_data = '0;
        iss_en = 1'b1; iss_addr = 5'd4;
        ra = '0; nb_ra = '0; t3_ra = '0;
        tick();
        reset = 1'b0;
        idle();

        // reset state
        ra = {5'd1, 5'd0}; #1;
        check("rst_d_a0_a1", rd, 64'h0);
        check("rst_busy_a0_a1", {62'd0, rb}, 64'h0);
        check("rst_busy_any", {63'd0, bany}, 64'h0);
        ra = {5'd31, 5'd4}; #1;
        check("rst_d_a4_a31", rd, 64'h0);
        check("rst_busy_a4_a31", {62'd0, rb}, 64'h0);

        // bypass vs stored read
        w0_en = 1'b1; w0_addr = 5'd6; w0_data = 32'h13;
        ra = {5'd0, 5'd6}; nb_ra = {5'd0, 5'd6}; #1;
        check("byp_same_cycle", {32'd0, rd[31:0]}, 64'h13);
        check("nobyp_same_cycle", {32'd0, nb_rd[31:0]}, 64'h0);
        tick(); idle(); #1;
        check("byp_next_cycle", {32'd0, rd[31:0]}, 64'h13);
        check("nobyp_next_cycle", {32'd0, nb_rd[31:0]}, 64'h13);

        // dual write collision, port 1 wins
        w0_en = 1'b1; w0_addr = 5'd9; w0_data = 32'hAA;
        w1_en = 1'b1; w1_addr = 5'd9; w1_data = 32'hBB;
        ra = {5'd0, 5'd9}; nb_ra = {5'd0, 5'd9}; #1;
        check("collide_byp", {32'd0, rd[31:0]}, 64'hBB);
        tick(); idle(); #1;
        check("collide_stored", {32'd0, rd[31:0]}, 64'hBB);
        check("collide_stored_nb", {32'd0, nb_rd[31:0]}, 64'hBB);

        // register 0 protection
        w0_en = 1'b1; w0_addr = 5'd0; w0_data = 32'hFE;
        iss_en = 1'b1; iss_addr = 5'd0;
        ra = {5'd0, 5'd0}; #1;
        check("zero_byp", rd, 64'h0);
        tick(); idle(); #1;
        check("zero_stored", rd, 64'h0);
        check("zero_busy", {62'd0, rb}, 64'h0);
        check("zero_busy_any", {63'd0, bany}, 64'h0);

        // scoreboard
        iss_en = 1'b1; iss_addr = 5'd5;
        ra = {5'd5, 5'd0}; nb_ra = {5'd5, 5'd0}; #1;
        check("issue_not_yet", {62'd0, rb}, 64'h0);
        tick(); idle(); #1;
        check("issue_busy", {62'd0, rb}, 64'h2);
        check("issue_busy_any", {63'd0, bany}, 64'h1);
        w1_en = 1'b1; w1_addr = 5'd5; w1_data = 32'h55;
        iss_en = 1'b1; iss_addr = 5'd5; #1;
        check("w1_fwd_busy", {62'd0, rb}, 64'h0);
        check("w1_fwd_data", {32'd0, rd[63:32]}, 64'h55);
        check("w1_nb_busy", {62'd0, nb_rb}, 64'h2);
        tick(); idle(); #1;
        check("issue_wins_busy", {62'd0, rb}, 64'h2);
        check("issue_wins_data", {32'd0, rd[63:32]}, 64'h55);
        w0_en = 1'b1; w0_addr = 5'd5; w0_data = 32'h66; #1;
        check("w0_fwd_busy", {62'd0, rb}, 64'h0);
        check("w0_fwd_data", {32'd0, rd[63:32]}, 64'h66);
        check("w0_nb_busy", {62'd0, nb_rb}, 64'h2);
        check("w0_nb_data", {32'd0, nb_rd[63:32]}, 64'h55);
        check("w0_busy_any_reg", {63'd0, bany}, 64'h1);
        tick(); idle(); #1;
        check("clear_busy", {62'd0, rb}, 64'h0);
        check("clear_busy_any", {63'd0, bany}, 64'h0);

        // reset mid-flight
        iss_en = 1'b1; iss_addr = 5'd3;
        tick();
        iss_addr = 5'd7;
        ra = {5'd7, 5'd3}; #1;
        check("pre_rst_busy", {62'd0, rb}, 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0; idle(); #1;
        check("mid_rst_busy", {62'd0, rb}, 64'h0);
        check("mid_rst_busy_any", {63'd0, bany}, 64'h0);
        ra = {5'd9, 5'd6}; #1;
        check("mid_rst_data", rd, 64'h0);

        // three read ports, no crosstalk
        w0_en = 1'b1; w0_addr = 5'd1; w0_data = 32'h14;
        w1_en = 1'b1; w1_addr = 5'd2; w1_data = 32'h40;
        tick(); idle();
        w0_en = 1'b1; w0_addr = 5'd6; w0_data = 32'h32;
        tick(); idle();
        t3_ra = {5'd6, 5'd2, 5'd1}; #1;
        check("t3_port0", {32'd0, t3_rd[31:0]}, 64'h14);
        check("t3_port1", {32'd0, t3_rd[63:32]}, 64'h40);
        check("t3_port2", {32'd0, t3_rd[95:64]}, 64'h32);
        t3_ra = {5'd1, 5'd6, 5'd2}; #1;
        check("t3_swap", {32'd0, t3_rd[95:64]}, 64'h14);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
